// File: rtl/commit_trace_packer.sv
// Commit trace packer: packs retired instructions into 128-bit words and
// buffers them in a 2-entry FIFO ahead of an external FIFO write port.
module commit_trace_packer (
  input  logic         clk,
  input  logic         reset,
  input  logic         commit_valid,
  output logic         commit_ready,
  input  logic [39:0]  commit_pc,
  input  logic [0:0]   commit_wen,
  input  logic [4:0]   commit_rd,
  input  logic [63:0]  commit_wdata,
  input  logic [0:0]   commit_mmio,
  input  logic [0:0]   commit_delayed,
  input  logic         halt,
  input  logic         flush,
  input  logic         fifo_full,
  output logic [127:0] fifo_wr_data,
  output logic [0:0]   fifo_wr_en,
  output logic [31:0]  packed_count,
  output logic [31:0]  stall_cycles,
  output logic [1:0]   debug_state
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   count_q, count_d;
  logic [127:0] buf0_q, buf0_d;
  logic [127:0] buf1_q, buf1_d;
  logic [31:0]  packed_q, packed_d;
  logic [31:0]  stall_q, stall_d;

  logic         wen_eff;
  logic [127:0] packed_word;
  logic         pop;
  logic         push;

  always_comb begin
    wen_eff     = commit_wen[0] && (commit_rd != '0);
    packed_word = {commit_wdata, commit_mmio, wen_eff, commit_rd,
                   commit_delayed, 16'h0000, commit_pc};
    // A flush cycle suppresses both the write and the handshake so that
    // neither buffered entries nor the coincident commit leak through.
    pop          = (count_q != 2'd0) && !fifo_full && !flush && (state_q != FLUSH);
    commit_ready = !reset && !flush && (state_q == RUN) && ((count_q != 2'd2) || pop);
    push         = commit_valid && commit_ready;

    fifo_wr_en   = pop;
    fifo_wr_data = buf0_q;
    packed_count = packed_q;
    stall_cycles = stall_q;
    debug_state  = state_q;
  end

  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (pop) begin
      buf0_d = buf1_q;
    end
    if (push) begin
      if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
        buf0_d = packed_word;
      end else begin
        buf1_d = packed_word;
      end
    end

    if (flush || (state_q == FLUSH)) begin
      count_d = '0;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    packed_d = packed_q + {31'd0, pop};
    stall_d  = stall_q;
    if ((count_q == 2'd2) && fifo_full && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end

    state_d = state_q;
    if (flush) begin
      state_d = FLUSH;
    end else begin
      unique case (state_q)
        RUN:     if (halt) state_d = HALT;
        HALT:    if (!halt && (count_q == 2'd0)) state_d = RUN;
        FLUSH:   state_d = halt ? HALT : RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      count_q  <= '0;
      buf0_q   <= '0;
      buf1_q   <= '0;
      packed_q <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      buf0_q   <= buf0_d;
      buf1_q   <= buf1_d;
      packed_q <= packed_d;
      stall_q  <= stall_d;
    end
  end

endmodule

// File: tb/tb_commit_trace_packer.sv
// Scoreboard bench for commit_trace_packer: a behavioural model predicts
// handshake, state and statistics; packed words are queued on acceptance.
module tb_commit_trace_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic         commit_valid;
  logic         commit_ready;
  logic [39:0]  commit_pc;
  logic [0:0]   commit_wen;
  logic [4:0]   commit_rd;
  logic [63:0]  commit_wdata;
  logic [0:0]   commit_mmio;
  logic [0:0]   commit_delayed;
  logic         halt;
  logic         flush;
  logic         fifo_full;
  logic [127:0] fifo_wr_data;
  logic [0:0]   fifo_wr_en;
  logic [31:0]  packed_count;
  logic [31:0]  stall_cycles;
  logic [1:0]   debug_state;

  commit_trace_packer dut (
    .clk(clk), .reset(reset),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_pc(commit_pc), .commit_wen(commit_wen), .commit_rd(commit_rd),
    .commit_wdata(commit_wdata), .commit_mmio(commit_mmio),
    .commit_delayed(commit_delayed),
    .halt(halt), .flush(flush), .fifo_full(fifo_full),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en),
    .packed_count(packed_count), .stall_cycles(stall_cycles),
    .debug_state(debug_state)
  );

  always #5 clk = ~clk;

  int unsigned  n_vec = 0;
  int unsigned  n_bad = 0;
  logic [127:0] q[$];
  int           m_state;
  logic [31:0]  m_packed;
  logic [31:0]  m_stall;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack(input logic [39:0] pc, input logic wen,
                                        input logic [4:0] rd, input logic [63:0] wd,
                                        input logic mmio, input logic dly);
    logic [127:0] w;
    w          = '0;
    w[127:64]  = wd;
    w[63]      = mmio;
    w[62]      = wen & (rd != 5'd0);
    w[61:57]   = rd;
    w[56]      = dly;
    w[39:0]    = pc;
    return w;
  endfunction

  task automatic model_reset();
    q.delete();
    m_state  = 0;
    m_packed = '0;
    m_stall  = '0;
  endtask

  // Check at the falling edge, advance the model at the rising edge,
  // and return 1 time unit later so the caller can change inputs.
  task automatic step();
    int   cnt;
    logic e_pop, e_rdy, acc;
    @(negedge clk);
    cnt   = q.size();
    e_pop = (cnt != 0) && !fifo_full && !flush && (m_state != 2);
    e_rdy = !reset && !flush && (m_state == 0) && ((cnt < 2) || e_pop);
    check("ready", 128'(commit_ready), 128'(e_rdy));
    check("wr_en", 128'(fifo_wr_en), 128'(e_pop));
    if (e_pop) check("wr_data", fifo_wr_data, q[0]);
    check("state", 128'(debug_state), 128'(m_state));
    check("packed_count", 128'(packed_count), 128'(m_packed));
    check("stall_cycles", 128'(stall_cycles), 128'(m_stall));
    @(posedge clk);
    if (!reset) begin
      acc = commit_valid && e_rdy;
      if ((cnt == 2) && fifo_full && (m_stall != 32'hFFFF_FFFF)) m_stall++;
      if (e_pop) m_packed++;
      if (flush) begin
        q.delete();
        m_state = 2;
      end else begin
        if (e_pop) void'(q.pop_front());
        if (acc) q.push_back(pack(commit_pc, commit_wen[0], commit_rd, commit_wdata,
                                  commit_mmio[0], commit_delayed[0]));
        case (m_state)
          0: if (halt) m_state = 1;
          1: if (!halt && (cnt == 0)) m_state = 0;
          default: m_state = halt ? 1 : 0;
        endcase
      end
    end
    #1;
  endtask

  task automatic rand_commit(input logic v);
    commit_valid   = v;
    commit_pc      = {$urandom, $urandom};
    commit_wen     = 1'($urandom);
    commit_rd      = 5'($urandom);
    commit_wdata   = {$urandom, $urandom};
    commit_mmio    = 1'($urandom);
    commit_delayed = 1'($urandom);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ready"}, 128'(commit_ready), 128'(0));
    check({tag, "_wr_en"}, 128'(fifo_wr_en), 128'(0));
    check({tag, "_wr_data"}, fifo_wr_data, '0);
    check({tag, "_packed"}, 128'(packed_count), 128'(0));
    check({tag, "_stall"}, 128'(stall_cycles), 128'(0));
    check({tag, "_state"}, 128'(debug_state), 128'(0));
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0; flush = 1'b0; fifo_full = 1'b0;
    rand_commit(1'b0);
    model_reset();
    #1 check_zero_outputs("reset");
    step(); step();
    reset = 1'b0;
    step();

    // Reference commit with a known packed image
    commit_valid = 1'b1; commit_pc = 40'h80000000; commit_wen = 1'b1; commit_rd = 5'd5;
    commit_wdata = 64'h1234; commit_mmio = 1'b0; commit_delayed = 1'b0;
    step();
    commit_valid = 1'b0;
    #1 check("ref_wr_en", 128'(fifo_wr_en), 128'(1));
    check("ref_wr_data", fifo_wr_data, 128'h0000000000001234_4A00000080000000);
    step(); step();
    check("ref_packed_count", 128'(packed_count), 128'(1));

    // Write to x0 must not flag a register write
    rand_commit(1'b1); commit_wen = 1'b1; commit_rd = 5'd0;
    step();
    commit_valid = 1'b0;
    #1 check("x0_bits", 128'(fifo_wr_data[62:57]), 128'(0));
    step(); step();

    // Back-pressure for 10 cycles with back-to-back commits
    fifo_full = 1'b1;
    repeat (10) begin rand_commit(1'b1); step(); end
    check("bp_stall", 128'(stall_cycles), 128'(8));
    fifo_full = 1'b0; commit_valid = 1'b0;
    repeat (4) step();

    // Halt with two buffered entries
    fifo_full = 1'b1;
    repeat (3) begin rand_commit(1'b1); step(); end
    halt = 1'b1; fifo_full = 1'b0;
    repeat (4) begin rand_commit(1'b1); step(); end
    halt = 1'b0; commit_valid = 1'b0;
    repeat (3) step();

    // Flush with two buffered entries and a coincident commit
    fifo_full = 1'b1;
    repeat (3) begin rand_commit(1'b1); step(); end
    flush = 1'b1; fifo_full = 1'b0; rand_commit(1'b1);
    step();
    flush = 1'b0; commit_valid = 1'b0;
    repeat (3) step();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      rand_commit(1'($urandom_range(0, 2) != 0));
      fifo_full = ($urandom_range(0, 9) < 3);
      halt      = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 99) < 3);
      step();
    end
    halt = 1'b0; flush = 1'b0; fifo_full = 1'b0; commit_valid = 1'b0;
    repeat (6) step();

    // Asynchronous reset while entries are buffered
    fifo_full = 1'b1;
    repeat (3) begin rand_commit(1'b1); step(); end
    reset = 1'b1;
    #1 check_zero_outputs("midreset");
    model_reset();
    fifo_full = 1'b0; commit_valid = 1'b0;
    step();
    reset = 1'b0;
    rand_commit(1'b1);
    step();
    commit_valid = 1'b0;
    repeat (3) step();
    check("drained", 128'(q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/commit_trace_packer.md
COMMIT_TRACE_PACKER -- requirements
Module: commit_trace_packer

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port commit_valid, input, 1: the core presents a retired instruction.
REQ-004 SHALL have port commit_ready, output, 1: the packer accepts the instruction; a transfer occurs when valid && ready at a clock edge.
REQ-005 SHALL have ports commit_pc [39:0], commit_wen [0:0], commit_rd [4:0], commit_wdata [63:0], commit_mmio [0:0] and commit_delayed [0:0], all inputs: the retired-instruction fields.
REQ-006 SHALL have port halt, input, 1: the comparator requests that the core stop, driven from the comparator's DUT interrupt.
REQ-007 SHALL have port flush, input, 1: one-cycle pulse that discards buffered entries.
REQ-008 SHALL have port fifo_full, input, 1: FIFO_WRITE FULL.
REQ-009 SHALL have ports fifo_wr_data [127:0] and fifo_wr_en [0:0], outputs: FIFO_WRITE WR_DATA and WR_EN.
REQ-010 SHALL have ports packed_count [31:0] and stall_cycles [31:0], outputs: statistics.
REQ-011 SHALL have port debug_state [1:0], output: current FSM state.

Function
REQ-012 SHALL pack each accepted commit into 128 bits as follows:
- [127:64] wdata
- [63] mmio
- [62] wen_eff
- [61:57] rd
- [56] delayed
- [55:40] 16'h0000
- [39:0] pc
REQ-013 SHALL compute wen_eff = commit_wen && (commit_rd != 0); a write to x0 is packed with [62]=0.
REQ-014 SHALL buffer packed words in a 2-entry FIFO with count 0..2, FIFO order preserved.
REQ-015 SHALL drive fifo_wr_en = (count != 0) && !fifo_full combinationally, with fifo_wr_data = head entry; a write pops the head at the same edge.
REQ-016 SHALL give a latency of one cycle: a commit accepted at edge t appears on fifo_wr_en/fifo_wr_data in the cycle following t when count was 0 and fifo_full=0.
REQ-017 SHALL drive commit_ready = (state == RUN) && (count < 2, or count == 2 with a pop in the same cycle).
REQ-018 SHALL handle a push and pop in the same cycle by keeping count unchanged and advancing order correctly.
REQ-019 SHALL implement FSM states RUN=0, HALT=1 and FLUSH=2.
REQ-020 SHALL transition RUN->HALT when halt=1; commit_ready is 0 from the next cycle while buffered entries continue to drain.
REQ-021 SHALL transition HALT->RUN when halt=0 and count=0; if halt=0 and count>0, the FSM remains in HALT until drained.
REQ-022 SHALL transition from any state to FLUSH when flush=1, with priority over halt. In FLUSH:
- count<=0
- fifo_wr_en=0
- commit_ready=0
- the next state is HALT if halt=1, else RUN
REQ-023 SHALL ignore a commit that coincides with flush=1; it is not buffered.
REQ-024 SHALL increment packed_count on every cycle with fifo_wr_en=1, wrapping 32'hFFFF_FFFF->0.
REQ-025 SHALL increment stall_cycles on every cycle with count=2 && fifo_full=1, saturating at 32'hFFFF_FFFF.
REQ-026 SHALL never write while fifo_full=1, and SHALL never drop an accepted commit except on flush.

Reset
REQ-027 SHALL, on reset=1 asynchronously, set:
- state=RUN
- count=0
- packed_count=0
- stall_cycles=0
- fifo_wr_en=0
- fifo_wr_data=0
- commit_ready=0 while reset is asserted
REQ-028 SHALL, on reset deassertion, assert commit_ready=1 in the first cycle (RUN, count=0).
REQ-029 SHALL, on reset mid-transfer, lose buffered entries with no partial write issued.

Verification
REQ-030 SHALL cover: commit pc=40'h80000000, wen=1, rd=5, wdata=64'h1234 with fifo_full=0 -> next cycle fifo_wr_en=1, wr_data=128'h0000000000001234_4A00000080000000, packed_count=1.
REQ-031 SHALL cover: commit wen=1, rd=0 -> wr_data[62]=0 and wr_data[61:57]=0.
REQ-032 SHALL cover: fifo_full=1 held for 10 cycles with back-to-back commits -> 2 accepted, commit_ready=0, stall_cycles=8 or 9 per count=2 cycles, no wr_en; on release, two writes in order on consecutive cycles.
REQ-033 SHALL cover: halt=1 with count=2 and fifo_full=0 -> commit_ready=0, two drains, then after halt=0 state returns to RUN.
REQ-034 SHALL cover: flush with count=2 and commit_valid=1 -> count=0, no write of those entries, and the coincident commit is discarded.
REQ-035 SHALL cover: reset asserted mid-stream -> all outputs zero immediately; first write after release carries the first post-reset commit.
